// File: rtl/ps2_move_decoder_if.sv
// Bundle between the PS/2 byte source, the move decoder and the game core.
// master: the decoder side. slave: the byte source and the game side.
interface ps2_move_decoder_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] dir;
  logic       activate;
  logic       key_held;

  modport master (
    input  received_data, received_data_en, move_ready,
    output move_valid, dir, activate, key_held
  );

  modport slave (
    output received_data, received_data_en, move_ready,
    input  move_valid, dir, activate, key_held
  );
endinterface

// File: rtl/ps2_move_decoder.sv
// Turns PS/2 scan bytes into isometric moves (valid/ready) and an activate pulse.
// Optional held-arrow auto-repeat is built when PS2_MOVE_AUTOREPEAT_EN is defined.
module ps2_move_decoder #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int REPEAT_CYCLES  = 12500000
) (
  input  logic clock,
  input  logic resetn,
  ps2_move_decoder_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    held_dir;
  logic          space_held;
  logic          move_valid_q;
  logic [1:0]    dir_q;
  logic          activate_q;
  logic          key_held_q;

  logic       strobe;
  logic [7:0] rx;
  logic       is_arrow;
  logic [1:0] arrow_code;
  logic       arrow_issue;
  logic       arrow_release;
  logic       rep_fire;

  assign strobe = bus.received_data_en;
  assign rx     = bus.received_data;

  always_comb begin
    is_arrow   = 1'b1;
    arrow_code = 2'd0;
    case (rx)
      8'h75:   arrow_code = 2'd2;
      8'h6B:   arrow_code = 2'd0;
      8'h72:   arrow_code = 2'd1;
      8'h74:   arrow_code = 2'd3;
      default: is_arrow = 1'b0;
    endcase
  end

  // A make of the arrow already held is typematic and must not move again.
  assign arrow_issue   = strobe && (state == EXT) && is_arrow &&
                         !(key_held_q && (held_dir == arrow_code));
  assign arrow_release = strobe && (state == EXT_BRK) && is_arrow &&
                         key_held_q && (held_dir == arrow_code);

`ifdef PS2_MOVE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_cnt;

  // The period only advances while no move is waiting on the game.
  assign rep_fire = key_held_q && !move_valid_q && !arrow_release &&
                    (rep_cnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rep_cnt <= '0;
    end else if (arrow_issue || rep_fire || !key_held_q) begin
      rep_cnt <= '0;
    end else if (!move_valid_q) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  // No repeat engine: the always-false compare keeps the parameter referenced.
  assign rep_fire = (REPEAT_CYCLES < 0);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      held_dir     <= 2'd0;
      space_held   <= 1'b0;
      move_valid_q <= 1'b0;
      dir_q        <= 2'd0;
      activate_q   <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      activate_q <= 1'b0;

      if (strobe) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: begin
            if (rx == 8'hE0) begin
              state <= EXT;
            end else if (rx == 8'hF0) begin
              state <= BRK;
            end else if (rx == 8'h29 && !space_held) begin
              activate_q <= 1'b1;
              space_held <= 1'b1;
            end
          end
          EXT:     state <= (rx == 8'hF0) ? EXT_BRK : IDLE;
          BRK: begin
            if (rx == 8'h29) space_held <= 1'b0;
            state <= IDLE;
          end
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // An orphaned prefix is dropped so a lost byte cannot wedge the parser.
        if (tmo_cnt == TMO_LAST) begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      if (arrow_issue) begin
        held_dir   <= arrow_code;
        key_held_q <= 1'b1;
      end else if (arrow_release) begin
        key_held_q <= 1'b0;
      end

      // A fresh issue beats a simultaneous transfer; latest direction wins.
      if (arrow_issue) begin
        move_valid_q <= 1'b1;
        dir_q        <= arrow_code;
      end else if (rep_fire) begin
        move_valid_q <= 1'b1;
        dir_q        <= held_dir;
      end else if (move_valid_q && bus.move_ready) begin
        move_valid_q <= 1'b0;
      end
    end
  end

  assign bus.move_valid = move_valid_q;
  assign bus.dir        = dir_q;
  assign bus.activate   = activate_q;
  assign bus.key_held   = key_held_q;
endmodule

// File: tb/tb_ps2_move_decoder.sv
// Scoreboard bench for ps2_move_decoder: expected moves are queued as bytes are
// sent and popped when a valid/ready transfer is observed.
`timescale 1ns/1ps
module tb_ps2_move_decoder;
  localparam int TMO = 16;
  localparam int REP = 32;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  ps2_move_decoder_if bus();

  ps2_move_decoder #(.TIMEOUT_CYCLES(TMO), .REPEAT_CYCLES(REP)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.master)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cycle    = 0;
  int         spurious = 0;
  int         act_count = 0;
  logic       prev_act = 1'b0;
  logic [1:0] exp_q[$];
  int         xfer_times[$];
  logic [1:0] exp_dir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  always @(posedge clock) cycle <= cycle + 1;

  // Transfer and activate monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (resetn && bus.move_valid && bus.move_ready) begin
      xfer_times.push_back(cycle);
      $display("move transfer dir=%0d cycle=%0d", bus.dir, cycle);
      if (exp_q.size() == 0) begin
        spurious++;
        $display("unexpected move dir=%0d cycle=%0d", bus.dir, cycle);
      end else begin
        exp_dir = exp_q.pop_front();
        check("move_dir", {30'd0, bus.dir}, {30'd0, exp_dir});
      end
    end
    if (bus.activate) begin
      act_count++;
      check("act_width", {31'd0, prev_act}, 32'd0);
    end
    prev_act = bus.activate;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clock);
    #1;
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(posedge clock);
    #1;
    bus.received_data_en = 1'b0;
    $display("byte %02h cycle=%0d", b, cycle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.received_data    = 8'h00;
    bus.received_data_en = 1'b0;
    bus.move_ready       = 1'b0;
    resetn               = 1'b0;
    tick(3);
    check("rst_valid",    {31'd0, bus.move_valid}, 0);
    check("rst_dir",      {30'd0, bus.dir}, 0);
    check("rst_activate", {31'd0, bus.activate}, 0);
    check("rst_key_held", {31'd0, bus.key_held}, 0);
    resetn = 1'b1;
    tick(1);

    // Up arrow held back by a busy game, then one transfer
    send(8'hE0);
    check("t1_no_early", {31'd0, bus.move_valid}, 0);
    exp_q.push_back(2'd2);
    send(8'h75);
    check("t1_latency", {31'd0, bus.move_valid}, 1);
    check("t1_dir", {30'd0, bus.dir}, 2);
    tick(10);
    check("t1_hold_valid", {31'd0, bus.move_valid}, 1);
    check("t1_hold_dir", {30'd0, bus.dir}, 2);
    bus.move_ready = 1'b1;
    tick(1);
    check("t1_cleared", {31'd0, bus.move_valid}, 0);
    check("t1_dir_kept", {30'd0, bus.dir}, 2);

    // Right arrow with typematic repeat, then release
    exp_q.push_back(2'd3);
    send(8'hE0); send(8'h74);
    tick(2);
    check("t2_held", {31'd0, bus.key_held}, 1);
    send(8'hE0); send(8'h74);
    check("t2_typematic", {31'd0, bus.move_valid}, 0);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("t2_released", {31'd0, bus.key_held}, 0);

    // Overwrite of a pending move; release of a non-held arrow ignored
    bus.move_ready = 1'b0;
    exp_q.push_back(2'd0);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h72);
    void'(exp_q.pop_back());
    exp_q.push_back(2'd1);
    check("t3_valid", {31'd0, bus.move_valid}, 1);
    check("t3_dir", {30'd0, bus.dir}, 1);
    check("t3_held", {31'd0, bus.key_held}, 1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("t3_other_release", {31'd0, bus.key_held}, 1);
    bus.move_ready = 1'b1;
    tick(2);
    check("t3_drained", {31'd0, bus.move_valid}, 0);
    send(8'hE0); send(8'hF0); send(8'h72);
    check("t3_released", {31'd0, bus.key_held}, 0);

    // Space: make, repeat, break, make, repeat
    act_count = 0;
    send(8'h29);
    check("t4_act_pulse", {31'd0, bus.activate}, 1);
    send(8'h29);
    check("t4_act_repeat", {31'd0, bus.activate}, 0);
    send(8'hF0); send(8'h29); send(8'h29); send(8'h29);
    tick(2);
    check("t4_act_count", act_count, 2);

    // Prefix timeout: one idle cycle short survives, exact limit drops
    exp_q.push_back(2'd2);
    send(8'hE0); tick(TMO - 2); send(8'h75);
    check("t5_edge_valid", {31'd0, bus.move_valid}, 1);
    check("t5_edge_dir", {30'd0, bus.dir}, 2);
    tick(2);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t5_edge_release", {31'd0, bus.key_held}, 0);
    send(8'hE0); tick(TMO - 1); send(8'h75);
    check("t5_timeout_valid", {31'd0, bus.move_valid}, 0);
    check("t5_timeout_held", {31'd0, bus.key_held}, 0);

    // Reset mid-prefix with a move pending
    bus.move_ready = 1'b0;
    exp_q.push_back(2'd2);
    send(8'hE0); send(8'h75);
    send(8'hE0);
    resetn = 1'b0;
    exp_q.delete();
    tick(1);
    check("t5_rst_valid", {31'd0, bus.move_valid}, 0);
    check("t5_rst_dir", {30'd0, bus.dir}, 0);
    check("t5_rst_activate", {31'd0, bus.activate}, 0);
    check("t5_rst_held", {31'd0, bus.key_held}, 0);
    resetn = 1'b1;
    tick(1);
    send(8'h75);
    check("t5_after_rst", {31'd0, bus.move_valid}, 0);

    // Held left arrow with game always ready
    bus.move_ready = 1'b1;
    tick(2);
    xfer_times.delete();
    exp_q.push_back(2'd0);
`ifdef PS2_MOVE_AUTOREPEAT_EN
    repeat (3) exp_q.push_back(2'd0);
`endif
    send(8'hE0); send(8'h6B);
    tick(105);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("t6_released", {31'd0, bus.key_held}, 0);
    tick(100);
`ifdef PS2_MOVE_AUTOREPEAT_EN
    check("t6_move_count", xfer_times.size(), 4);
    for (int i = 1; i < xfer_times.size(); i++)
      check("t6_period", xfer_times[i] - xfer_times[i-1], REP + 1);
`else
    check("t6_move_count", xfer_times.size(), 1);
`endif

    check("queue_empty", exp_q.size(), 0);
    check("spurious_moves", spurious, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ps2_move_decoder.md
Name: ps2_move_decoder

Overview:
- Converts raw PS/2 keyboard bytes into the game's movement and activation commands.
- Sits between PS2_Controller (received_data / received_data_en) and the MonumentValley game core.
- Parses E0/F0 prefixes, suppresses typematic repeats and maps arrow keys to the 2-bit isometric direction code.
- Offers each move over a valid/ready handshake so no keypress is lost while the game is busy.

Parameters:
- TIMEOUT_CYCLES, 2500000, cycles a prefix (E0/F0) may wait for its next byte before the parser abandons it (50 ms at 50 MHz).
- REPEAT_CYCLES, 12500000, auto-repeat period while an arrow is held (250 ms); used only with the optional feature.

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- received_data  in  8  byte from PS2_Controller
- received_data_en  in  1  one-cycle strobe, received_data valid
- move_ready  in  1  game can accept a move this cycle
- move_valid  out  1  move command pending
- dir  out  2  direction of pending move: 0 bottom-left, 1 bottom-right, 2 top-left, 3 top-right
- activate  out  1  one-cycle pulse on space press
- key_held  out  1  an arrow key is currently held

Behaviour:
- Reset (async, resetn=0): state IDLE; move_valid=0, dir=0, activate=0, key_held=0; held_dir=0; space_held=0; timeout counter=0. Reset mid-sequence discards any partial prefix and any pending move.
- Bytes are consumed only in cycles with received_data_en=1. Other cycles only advance the timeout counter.
- Parser FSM:
  - IDLE: E0 -> EXT; F0 -> BRK; 29 -> space make; other bytes ignored.
  - EXT: F0 -> EXT_BRK; 75/6B/72/74 -> arrow make, then IDLE; any other byte -> IDLE.
  - BRK: 29 -> space break, then IDLE; any other byte -> IDLE.
  - EXT_BRK: 75/6B/72/74 -> arrow break, then IDLE; any other byte -> IDLE.
  - In EXT, BRK or EXT_BRK the timeout counter runs. At TIMEOUT_CYCLES-1 with no strobe, return to IDLE. The counter clears on every accepted byte and on entering IDLE.
- Arrow mapping: 75 (UP) -> 2, 6B (LEFT) -> 0, 72 (DOWN) -> 1, 74 (RIGHT) -> 3.
- Arrow make:
  - Same direction while key_held=1 with held_dir equal: typematic repeat, ignored.
  - Otherwise: held_dir <= code; key_held <= 1; issue a move.
- Arrow break: if key_held=1 and the code equals held_dir, key_held <= 0. Breaks of non-held arrows are ignored.
- Issue a move: move_valid <= 1 and dir <= code on the clock edge following the final byte's strobe (1-cycle latency). If a move is already pending, dir is overwritten (latest wins) and move_valid stays 1.
- Handshake:
  - Transfer occurs on a cycle where move_valid=1 and move_ready=1; move_valid clears the next edge.
  - dir is stable while move_valid=1, except on an overwrite.
  - If a transfer and a new issue coincide, the new issue wins: move_valid stays 1 with the new dir.
  - dir holds its last value after the transfer.
- Space:
  - Make with space_held=0: activate=1 for exactly one cycle (edge after the strobe), and space_held <= 1.
  - Repeat makes are ignored.
  - Break clears space_held.
  - activate is independent of the move handshake.

Optional Feature:
- Macro: PS2_MOVE_AUTOREPEAT_EN.
- Defined:
  - A repeat counter clears on every arrow move issue and counts while key_held=1 and move_valid=0.
  - At REPEAT_CYCLES-1 it issues a move with dir=held_dir and clears.
  - Releasing the key stops repeats immediately.
- Undefined: no repeat counter is built; a held key produces exactly one move.

Test Plan:
- Bytes E0,75 with move_ready=0 for 10 cycles, then 1 -> move_valid=1 one edge after the 75 strobe; dir=2 held; one transfer; move_valid=0 the following edge.
- E0,74 then E0,74 (typematic) then E0,F0,74 -> exactly one move, dir=3; key_held 1 -> 0 after the final 74.
- E0,6B, then E0,72 while move_ready=0 -> single pending move with dir=1; key_held=1; held_dir=1; release E0,F0,6B leaves key_held=1.
- 29,29,F0,29,29 -> activate pulses exactly twice, each 1 cycle wide.
- E0 followed by no bytes for TIMEOUT_CYCLES (bench sets 16), then 75 -> no move; FSM back in IDLE; 75 ignored. E0 then resetn=0 mid-prefix -> all outputs 0.
- With PS2_MOVE_AUTOREPEAT_EN, REPEAT_CYCLES=32, move_ready=1: hold E0,6B -> moves with dir=0 every 33 cycles until E0,F0,6B, then none. Without the macro -> one move only.
